// File: rtl/trigger_hub_pkg.sv
// trigger_hub_pkg: command codes, default bus layout and FSM state type
// shared by the trigger hub and its testbench.
package trigger_hub_pkg;

    // Command codes on the uc bus
    localparam logic [2:0] TRIGGER_OUT_CMD = 3'h3;
    localparam logic [2:0] TRIGGER_IN_CMD  = 3'h2;

    // Default field widths; the bus packs {length, address, cmd, data} MSB..LSB
    localparam int DEF_DATA_W = 8;
    localparam int DEF_CMD_W  = 3;
    localparam int DEF_ADDR_W = 3;
    localparam int DEF_LEN_W  = 8;

    localparam int DATA_OFF = 0;
    localparam int CMD_OFF  = DATA_OFF + DEF_DATA_W;
    localparam int ADDR_OFF = CMD_OFF + DEF_CMD_W;
    localparam int LEN_OFF  = ADDR_OFF + DEF_ADDR_W;
    localparam int UC_BUS_W = LEN_OFF + DEF_LEN_W;

    // Host-direction packet scheduler states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } hub_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/trigger_rr_arbiter.sv
// trigger_rr_arbiter: combinational round-robin search. Returns the first
// set request at or after i_ptr, wrapping at N.
module trigger_rr_arbiter #(
    parameter int N     = 1,
    parameter int PTR_W = 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic             o_found,
    output logic [PTR_W-1:0] o_idx
);

    int w_j;

    // Walk offsets from farthest to nearest so the nearest set request is the last writer
    always_comb begin
        o_found = 1'b0;
        o_idx   = '0;
        w_j     = 0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = int'(i_ptr) + k;
            if (w_j >= N) w_j = w_j - N;
            if (i_req[w_j]) begin
                o_found = 1'b1;
                o_idx   = PTR_W'(w_j);
            end
        end
    end

endmodule

// File: rtl/trigger_hub.sv
// trigger_hub: bidirectional trigger endpoint on the uc host bus.
// Host direction: sticky edge capture, round-robin packetisation onto uc_out.
// Device direction: TRIGGER_IN_CMD packets become one-cycle segment pulses.
// Optional build macro: TRIGGER_OVERFLOW_EN adds per-segment overflow flags.
module trigger_hub
    import trigger_hub_pkg::*;
#(
    parameter int DATA_W      = 8,
    parameter int NSEG        = 1,
    parameter int CMD_W       = 3,
    parameter int ADDR_W      = 3,
    parameter int LEN_W       = 8,
    parameter int HOLD_CYCLES = 4,
    parameter int GAP_CYCLES  = 1,
    localparam int TRIG_W     = NSEG * DATA_W,
    localparam int BUS_W      = LEN_W + ADDR_W + CMD_W + DATA_W
) (
    input  logic              uc_clk,
    input  logic              uc_reset,
    input  logic [BUS_W-1:0]  uc_in,
    output logic [BUS_W-1:0]  uc_out,
    input  logic [TRIG_W-1:0] trigger_to_host,
    output logic [TRIG_W-1:0] trigger_to_device,
    output logic              busy
`ifdef TRIGGER_OVERFLOW_EN
    ,
    output logic [NSEG-1:0]   overflow,
    input  logic [NSEG-1:0]   overflow_clr
`endif
);

    localparam int B_CMD_OFF  = DATA_W;
    localparam int B_ADDR_OFF = DATA_W + CMD_W;
    localparam int PTR_W      = (NSEG > 1) ? $clog2(NSEG) : 1;
    localparam int CNT_W      = $clog2(max_int(HOLD_CYCLES, GAP_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    logic [TRIG_W-1:0] r_prev;
    logic [TRIG_W-1:0] r_pending;
    logic [TRIG_W-1:0] w_rise;
    logic [TRIG_W-1:0] w_clr;
    logic [NSEG-1:0]   w_seg_req;
    hub_state_t        r_state;
    hub_state_t        w_state_next;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_next;
    logic [PTR_W-1:0]  r_rr_ptr;
    logic [PTR_W-1:0]  w_sel;
    logic              w_found;
    logic              w_take;
    logic [DATA_W-1:0] r_tx_data;
    logic [ADDR_W-1:0] r_tx_addr;

    logic [ADDR_W-1:0] w_in_addr;
    logic              w_match;
    logic              r_match_prev;
    logic [TRIG_W-1:0] w_tdev_next;
    logic [TRIG_W-1:0] r_tdev;

    assign w_rise = trigger_to_host & ~r_prev;

    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
            assign w_seg_req[gi] = |r_pending[gi*DATA_W +: DATA_W];
            assign w_clr[gi*DATA_W +: DATA_W] =
                {DATA_W{w_take && (w_sel == PTR_W'(gi))}};
        end
    endgenerate

    trigger_rr_arbiter #(
        .N     (NSEG),
        .PTR_W (PTR_W)
    ) u_arb (
        .i_req   (w_seg_req),
        .i_ptr   (r_rr_ptr),
        .o_found (w_found),
        .o_idx   (w_sel)
    );

    // Edge capture: a rise in the same cycle as a clear keeps the bit pending
    always_ff @(posedge uc_clk or posedge uc_reset) begin
        if (uc_reset) begin
            r_prev    <= '0;
            r_pending <= '0;
        end else begin
            r_prev    <= trigger_to_host;
            r_pending <= (r_pending & ~w_clr) | w_rise;
        end
    end

    // Packet scheduler next state; IDLE always spends one cycle selecting
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_take       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_take       = 1'b1;
                    w_state_next = SEND;
                    w_cnt_next   = '0;
                end
            end
            SEND: begin
                if (r_cnt == HOLD_LAST) begin
                    w_state_next = GAP;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            GAP: begin
                if (r_cnt == GAP_LAST) begin
                    w_state_next = IDLE;
                    w_cnt_next   = '0;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // Scheduler state, counters, and the packet latched when a segment is taken
    always_ff @(posedge uc_clk or posedge uc_reset) begin
        if (uc_reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_rr_ptr  <= '0;
            r_tx_data <= '0;
            r_tx_addr <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            if (w_take) begin
                r_tx_data <= r_pending[int'(w_sel)*DATA_W +: DATA_W];
                r_tx_addr <= ADDR_W'(w_sel);
                r_rr_ptr  <= (w_sel == PTR_W'(NSEG - 1)) ? '0 : w_sel + 1'b1;
            end
        end
    end

    // uc_out carries the packet only while sending; length stays zero
    always_comb begin
        uc_out = '0;
        if (r_state == SEND) begin
            uc_out[DATA_W-1:0]               = r_tx_data;
            uc_out[B_CMD_OFF +: CMD_W]       = CMD_W'(TRIGGER_OUT_CMD);
            uc_out[B_ADDR_OFF +: ADDR_W]     = r_tx_addr;
        end
    end

    assign busy = (r_state != IDLE);

    // Device direction: pulse only on the first cycle of a valid command
    assign w_in_addr = uc_in[B_ADDR_OFF +: ADDR_W];
    assign w_match   = (uc_in[B_CMD_OFF +: CMD_W] == CMD_W'(TRIGGER_IN_CMD)) &&
                       ({1'b0, w_in_addr} < (ADDR_W+1)'(NSEG));

    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_dev
            assign w_tdev_next[gi*DATA_W +: DATA_W] =
                (w_match && !r_match_prev && (w_in_addr == ADDR_W'(gi)))
                    ? uc_in[DATA_W-1:0] : '0;
        end
    endgenerate

    // Register the device pulse and the previous match for first-cycle detection
    always_ff @(posedge uc_clk or posedge uc_reset) begin
        if (uc_reset) begin
            r_match_prev <= 1'b0;
            r_tdev       <= '0;
        end else begin
            r_match_prev <= w_match;
            r_tdev       <= w_tdev_next;
        end
    end

    assign trigger_to_device = r_tdev;

`ifdef TRIGGER_OVERFLOW_EN
    logic [TRIG_W-1:0] w_rerise;
    logic [NSEG-1:0]   w_ovf_set;
    logic [NSEG-1:0]   r_ovf;

    // A re-edge on a bit still pending (and not being handed off) is an overflow
    assign w_rerise = w_rise & r_pending & ~w_clr;

    generate
        for (genvar gi = 0; gi < NSEG; gi++) begin : g_ovf
            assign w_ovf_set[gi] = |w_rerise[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Sticky overflow flags; a set in the same cycle as a clear wins
    always_ff @(posedge uc_clk or posedge uc_reset) begin
        if (uc_reset) begin
            r_ovf <= '0;
        end else begin
            r_ovf <= (r_ovf & ~overflow_clr) | w_ovf_set;
        end
    end

    assign overflow = r_ovf;
`endif

endmodule

// File: tb/tb_trigger_hub.sv
// tb_trigger_hub: directed checks plus randomized traffic against a
// behavioural model of the trigger hub (NSEG=3, HOLD=4, GAP=1).
module tb_trigger_hub;
    import trigger_hub_pkg::*;

    localparam int DW   = 8;
    localparam int NS   = 3;
    localparam int CW   = 3;
    localparam int AW   = 3;
    localparam int LW   = 8;
    localparam int HOLD = 4;
    localparam int GAPC = 1;
    localparam int BW   = LW + AW + CW + DW;
    localparam int TW   = NS * DW;
    localparam int COFF = DW;
    localparam int AOFF = DW + CW;

    logic          uc_clk = 1'b0;
    logic          uc_reset = 1'b1;
    logic [BW-1:0] uc_in = '0;
    logic [BW-1:0] uc_out;
    logic [TW-1:0] trigger_to_host = '0;
    logic [TW-1:0] trigger_to_device;
    logic          busy;
`ifdef TRIGGER_OVERFLOW_EN
    logic [NS-1:0] overflow;
    logic [NS-1:0] overflow_clr = '0;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    bit checking = 1'b0;

    always #5 uc_clk = ~uc_clk;

    trigger_hub #(
        .DATA_W      (DW),
        .NSEG        (NS),
        .CMD_W       (CW),
        .ADDR_W      (AW),
        .LEN_W       (LW),
        .HOLD_CYCLES (HOLD),
        .GAP_CYCLES  (GAPC)
    ) dut (
        .uc_clk            (uc_clk),
        .uc_reset          (uc_reset),
        .uc_in             (uc_in),
        .uc_out            (uc_out),
        .trigger_to_host   (trigger_to_host),
        .trigger_to_device (trigger_to_device),
        .busy              (busy)
`ifdef TRIGGER_OVERFLOW_EN
        ,
        .overflow          (overflow),
        .overflow_clr      (overflow_clr)
`endif
    );

    function automatic logic [BW-1:0] pack(input int addr, input int cmd, input int data);
        logic [BW-1:0] v;
        v = BW'(data & 255) | (BW'(cmd & 7) << COFF) | (BW'(addr & 7) << AOFF);
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    logic [DW-1:0] m_pend [NS] = '{default: '0};
    logic [TW-1:0] m_prev = '0;
    logic [TW-1:0] m_rise;
    int            m_rr = 0;
    int            m_e = 0;
    int            m_start = -1000;
    int            m_sel;
    logic [BW-1:0] m_pkt = '0;
    bit            m_prev_match = 1'b0;
    bit            m_match;
    int            m_addr;
    logic [BW-1:0] exp_out = '0;
    logic          exp_busy = 1'b0;
    logic [TW-1:0] exp_tdev = '0;
`ifdef TRIGGER_OVERFLOW_EN
    logic [NS-1:0] m_ovf = '0;
`endif

    always @(posedge uc_clk or posedge uc_reset) begin
        if (uc_reset) begin
            for (int s = 0; s < NS; s++) m_pend[s] = '0;
            m_prev = '0; m_rr = 0; m_e = 0; m_start = -1000; m_pkt = '0;
            m_prev_match = 1'b0;
            exp_out = '0; exp_busy = 1'b0; exp_tdev = '0;
`ifdef TRIGGER_OVERFLOW_EN
            m_ovf = '0;
`endif
        end else begin
            m_rise = trigger_to_host & ~m_prev;
            m_sel = -1;
            // a new packet can be chosen only once hold, gap and one idle cycle have passed
            if (m_e - m_start >= HOLD + GAPC + 1) begin
                for (int k = 0; k < NS; k++) begin
                    if (m_sel < 0 && m_pend[(m_rr + k) % NS] != 0) m_sel = (m_rr + k) % NS;
                end
            end
            if (m_sel >= 0) begin
                m_pkt   = pack(m_sel, int'(TRIGGER_OUT_CMD), int'(m_pend[m_sel]));
                m_start = m_e;
                m_rr    = (m_sel + 1) % NS;
            end
`ifdef TRIGGER_OVERFLOW_EN
            m_ovf = m_ovf & ~overflow_clr;
`endif
            for (int s = 0; s < NS; s++) begin
`ifdef TRIGGER_OVERFLOW_EN
                if (s != m_sel && (m_rise[s*DW +: DW] & m_pend[s]) != 0) m_ovf[s] = 1'b1;
`endif
                if (s == m_sel) m_pend[s] = m_rise[s*DW +: DW];
                else            m_pend[s] = m_pend[s] | m_rise[s*DW +: DW];
            end
            m_prev   = trigger_to_host;
            exp_out  = (m_e - m_start < HOLD) ? m_pkt : '0;
            exp_busy = (m_e - m_start < HOLD + GAPC);
            m_addr   = int'(uc_in[AOFF +: AW]);
            m_match  = (uc_in[COFF +: CW] == TRIGGER_IN_CMD) && (m_addr < NS);
            exp_tdev = (m_match && !m_prev_match) ? (TW'(uc_in[DW-1:0]) << (m_addr * DW)) : '0;
            m_prev_match = m_match;
            m_e++;
        end
    end

    // compare DUT against model every cycle
    always @(negedge uc_clk) begin
        if (checking) begin
            check("uc_out", 64'(uc_out), 64'(exp_out));
            check("busy", 64'(busy), 64'(exp_busy));
            check("trigger_to_device", 64'(trigger_to_device), 64'(exp_tdev));
`ifdef TRIGGER_OVERFLOW_EN
            check("overflow", 64'(overflow), 64'(m_ovf));
`endif
        end
    end

    // ---------------- directed helpers ----------------
    task automatic wait_start(output logic [BW-1:0] pkt);
        pkt = '0;
        for (int t = 0; t < 40; t++) begin
            @(negedge uc_clk);
            if (uc_out != '0) begin
                pkt = uc_out;
                return;
            end
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_start: no packet within 40 cycles at %0t", $time);
    endtask

    task automatic wait_end();
        for (int t = 0; t < 20; t++) begin
            if (uc_out == '0) return;
            @(negedge uc_clk);
        end
        n_cmp++; n_bad++;
        $display("FAIL wait_end: packet longer than 20 cycles at %0t", $time);
    endtask

    logic [BW-1:0] pkt;
    logic [CW-1:0] rcmd;

    initial begin
        uc_reset = 1'b1;
        @(negedge uc_clk);
        checking = 1'b1;
        @(negedge uc_clk);
        check("reset_uc_out", 64'(uc_out), 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_tdev", 64'(trigger_to_device), 64'd0);
        uc_reset = 1'b0;
        repeat (2) @(negedge uc_clk);

        // single edge on bit 0: packet appears two cycles later, held 4 cycles
        trigger_to_host = 24'h000001;
        @(negedge uc_clk);
        check("latency_not_yet", 64'(uc_out), 64'd0);
        @(negedge uc_clk);
        check("pkt0_first", 64'(uc_out), 64'(pack(0, int'(TRIGGER_OUT_CMD), 8'h01)));
        trigger_to_host = 24'h000005;          // bit 2 rises during SEND
        for (int i = 0; i < HOLD - 1; i++) begin
            @(negedge uc_clk);
            check("pkt0_hold", 64'(uc_out), 64'(pack(0, int'(TRIGGER_OUT_CMD), 8'h01)));
        end
        @(negedge uc_clk);
        check("pkt0_end", 64'(uc_out), 64'd0);
        wait_start(pkt);
        check("pkt_bit2", 64'(pkt), 64'(pack(0, int'(TRIGGER_OUT_CMD), 8'h04)));
        wait_end();
        trigger_to_host = '0;
        repeat (10) @(negedge uc_clk);

        // device direction: held command gives one pulse, bad address none
        uc_in = pack(1, int'(TRIGGER_IN_CMD), 8'hA5);
        @(negedge uc_clk);
        check("dev_pulse", 64'(trigger_to_device), 64'h00A500);
        for (int i = 0; i < 4; i++) begin
            @(negedge uc_clk);
            check("dev_held", 64'(trigger_to_device), 64'd0);
        end
        uc_in = '0;
        @(negedge uc_clk);
        uc_in = pack(3, int'(TRIGGER_IN_CMD), 8'h5A);
        repeat (2) begin
            @(negedge uc_clk);
            check("dev_bad_addr", 64'(trigger_to_device), 64'd0);
        end
        uc_in = '0;
        repeat (2) @(negedge uc_clk);

        // reset in the middle of a packet with more bits pending
        trigger_to_host = 24'h000001;
        repeat (3) @(negedge uc_clk);
        trigger_to_host = 24'h000009;
        @(negedge uc_clk);
        #2 uc_reset = 1'b1;
        #1;
        check("rst_async_out", 64'(uc_out), 64'd0);
        check("rst_async_busy", 64'(busy), 64'd0);
        trigger_to_host = '0;
        @(negedge uc_clk);
        uc_reset = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge uc_clk);
            check("post_rst_quiet", 64'(uc_out), 64'd0);
        end

        // round-robin order: segments 0 and 2 together, then 0 again during seg 2
        trigger_to_host = 24'h010001;
        wait_start(pkt);
        check("order_0", 64'(pkt), 64'(pack(0, int'(TRIGGER_OUT_CMD), 8'h01)));
        wait_end();
        wait_start(pkt);
        check("order_2", 64'(pkt), 64'(pack(2, int'(TRIGGER_OUT_CMD), 8'h01)));
        trigger_to_host = 24'h010003;
        wait_end();
        wait_start(pkt);
        check("order_0b", 64'(pkt), 64'(pack(0, int'(TRIGGER_OUT_CMD), 8'h02)));
        wait_end();
        repeat (4) @(negedge uc_clk);

        // lines high across reset produce exactly one packet
        trigger_to_host = 24'h000003;
        repeat (3) @(negedge uc_clk);
        uc_reset = 1'b1;
        @(negedge uc_clk);
        uc_reset = 1'b0;
        wait_start(pkt);
        check("rst_high_pkt", 64'(pkt), 64'(pack(0, int'(TRIGGER_OUT_CMD), 8'h03)));
        wait_end();
        for (int i = 0; i < 10; i++) begin
            @(negedge uc_clk);
            check("rst_high_once", 64'(uc_out), 64'd0);
        end

`ifdef TRIGGER_OVERFLOW_EN
        // toggle bit 1 twice while segment 0 is busy sending
        trigger_to_host = 24'h000000;
        repeat (10) @(negedge uc_clk);
        trigger_to_host = 24'h000001;
        repeat (2) @(negedge uc_clk);
        trigger_to_host = 24'h000003;
        @(negedge uc_clk);
        trigger_to_host = 24'h000001;
        @(negedge uc_clk);
        trigger_to_host = 24'h000003;
        @(negedge uc_clk);
        check("ovf_set", 64'(overflow), 64'd1);
        repeat (3) @(negedge uc_clk);
        check("ovf_sticky", 64'(overflow), 64'd1);
        overflow_clr = 3'b001;
        @(negedge uc_clk);
        overflow_clr = '0;
        check("ovf_clr", 64'(overflow), 64'd0);
        trigger_to_host = '0;
        repeat (10) @(negedge uc_clk);
`endif

        // randomized traffic checked by the model
        for (int c = 0; c < 3000; c++) begin
            @(negedge uc_clk);
            if ($urandom_range(0, 3) == 0)
                trigger_to_host = trigger_to_host ^ (TW'(1) << $urandom_range(0, TW - 1));
            if ($urandom_range(0, 9) == 0)
                trigger_to_host = trigger_to_host ^ (TW'(1) << $urandom_range(0, TW - 1));
            if ($urandom_range(0, 2) == 0) begin
                rcmd  = ($urandom_range(0, 1) == 1) ? TRIGGER_IN_CMD : CW'($urandom_range(0, 7));
                uc_in = pack(int'($urandom_range(0, 7)), int'(rcmd), int'($urandom_range(0, 255)));
            end
`ifdef TRIGGER_OVERFLOW_EN
            overflow_clr = ($urandom_range(0, 7) == 0) ? NS'($urandom_range(0, 7)) : '0;
`endif
            if ($urandom_range(0, 499) == 0) begin
                #2 uc_reset = 1'b1;
                #2 uc_reset = 1'b0;
            end
        end

        repeat (5) @(negedge uc_clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/trigger_hub.md
Name: trigger_hub

Overview:
- Parametrised bidirectional trigger endpoint on the uc host bus; successor to the single-byte active trigger.
- Host direction: captures rising edges on TRIG_W device trigger lines into sticky pending bits. Segments them into DATA_W-wide TRIGGER_OUT_CMD packets on uc_out, served round-robin with a fixed hold and gap.
- Device direction: decodes TRIGGER_IN_CMD packets from uc_in into one-cycle pulses on the addressed segment of trigger_to_device.

Parameters:
- DATA_W, 8, data field width; also the trigger segment width.
- NSEG, 1, number of trigger segments; TRIG_W = NSEG*DATA_W; NSEG must be ≤ 2**ADDR_W.
- CMD_W, 3, command field width.
- ADDR_W, 3, address field width; carries the segment index.
- LEN_W, 8, length field width.
- HOLD_CYCLES, 4, cycles a TRIGGER_OUT_CMD packet is held on uc_out (≥1).
- GAP_CYCLES, 1, idle cycles forced between consecutive packets (≥1).

Ports:
- uc_clk  in  1  system clock.
- uc_reset  in  1  asynchronous, active-high reset.
- uc_in  in  UC_BUS_W  host→device bus {length,address,cmd,data}.
- uc_out  out  UC_BUS_W  device→host bus, same packing.
- trigger_to_host  in  TRIG_W  device trigger levels, synchronous to uc_clk.
- trigger_to_device  out  TRIG_W  host trigger pulses.
- busy  out  1  high while the FSM is in SEND or GAP.

Behaviour:
- Reset (async, active-high): pending=0, prev=0, FSM=IDLE, rr_ptr=0.
  - uc_out=0, trigger_to_device=0, busy=0.
  - prev resets to 0, so lines already high when reset releases register as edges on the first clock.
- Edge capture, every cycle: rise = trigger_to_host & ~prev; prev <= trigger_to_host; pending <= (pending & ~clr) | rise.
  - If rise and clr hit the same bit in the same cycle, rise wins: the bit stays pending for a later packet.
- IDLE:
  - Select the first segment s with pending[s]≠0, searching from rr_ptr upward with wrap at NSEG.
  - If none is found, stay in IDLE.
  - If found: latch tx_data = pending[s], tx_addr = s; assert clr for segment s; go to SEND; rr_ptr <= s+1 mod NSEG.
- SEND:
  - uc_out drives data = tx_data, cmd = TRIGGER_OUT_CMD, address = tx_addr, length = 0.
  - Held for exactly HOLD_CYCLES cycles, then go to GAP.
  - Edges arriving during SEND accumulate in pending and are not merged into the current packet.
- GAP: uc_out = 0 for GAP_CYCLES cycles, then IDLE.
- Latency: an edge at the input in cycle n with the FSM idle appears on uc_out in cycle n+2 (one cycle edge register, one cycle select/latch).
- uc_out is zero in every state except SEND. The address field is zero except during SEND; the length field is always zero.
- Counters are sized to clog2(max(HOLD_CYCLES,GAP_CYCLES))+1 and must not wrap early.
- Device direction:
  - match = (uc_in.cmd == TRIGGER_IN_CMD) && (uc_in.address < NSEG).
  - On the first cycle of match after a non-match cycle, the next cycle drives trigger_to_device segment[uc_in.address] = uc_in.data for exactly one cycle; all other bits are 0.
  - A held command produces no further pulses. A command with address ≥ NSEG is ignored.
- Reset mid-packet: uc_out drops to 0 asynchronously and all pending triggers are discarded.

Optional Feature:
- Macro: TRIGGER_OVERFLOW_EN.
- Defined:
  - Adds output overflow [NSEG-1:0] and input overflow_clr [NSEG-1:0].
  - overflow[s] sets when a rise occurs on a bit already pending in segment s, excluding bits being cleared that cycle.
  - overflow[s] clears on overflow_clr[s]; if set and clear coincide, set wins.
  - Resets to 0.
- Undefined: these ports do not exist; re-edges on pending bits are silently merged.

Decomposition:
- Package trigger_hub_pkg:
  - TRIGGER_OUT_CMD = 3'h? and TRIGGER_IN_CMD constants, with values taken from the shared define set.
  - Bus field offsets and widths, UC_BUS_W.
  - FSM state typedef {IDLE, SEND, GAP}.
- Sub-module trigger_rr_arbiter: NSEG-way round-robin first-set search from rr_ptr; purely combinational, reusable.

Test Plan:
- NSEG=1, HOLD=4, GAP=1: raise trigger_to_host[0] once → uc_out data=0x01, cmd=TRIGGER_OUT_CMD, addr=0 for exactly 4 cycles starting 2 cycles later, then 0.
- Raise bit 2 during SEND of bit 0 → second packet with data 0x04 follows after the 1-cycle gap; the first packet stays 0x01.
- NSEG=3: simultaneous edges in segments 0 and 2, then another in 0 during the segment-2 packet → packet order addr 0, 2, 0.
- Host drives uc_in cmd=TRIGGER_IN_CMD, address=1, data=0xA5 for 5 cycles → trigger_to_device[15:8]=0xA5 for one cycle only; address=3 → no pulse.
- Assert uc_reset mid-SEND with pending bits → uc_out=0 immediately; no packets after release unless inputs are high (high inputs produce one packet).
- TRIGGER_OVERFLOW_EN defined: toggle bit 1 twice before its packet → overflow[0]=1 until overflow_clr[0] is pulsed.
